imm_encode: RTL

Streaming immediate encoder: the inverse of the IMM_PICK decoder. It takes an instruction template (opcode, registers, funct fields) and a 32-bit immediate value, scatters the immediate bits into the positions IMM_PICK reads them from, and flags immediates that the selected format cannot represent. It sits in the instruction-loader/relocation path ahead of instruction memory, with valid/ready handshakes on both sides and a two-stage stallable pipeline.

---
 rtl/imm_encode.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imm_encode.sv
// Streaming immediate encoder: scatters a 32-bit immediate into an instruction
// template for the I/S/U/B/J formats, with a two-stage stallable valid/ready pipeline.
module imm_encode #(
  parameter int ERR_W = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      IN_INSTRUCTION,
  input  logic [31:0]      IN_IMMEDIATE,
  input  logic [2:0]       IN_IMM_PICK,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [31:0]      OUT_INSTRUCTION,
  output logic             OUT_RANGE_ERR,
  input  logic             CLR_ERR,
  output logic [ERR_W-1:0] ERR_COUNT
);

  localparam logic [2:0] PICK_I = 3'b000;
  localparam logic [2:0] PICK_S = 3'b001;
  localparam logic [2:0] PICK_U = 3'b010;
  localparam logic [2:0] PICK_B = 3'b011;
  localparam logic [2:0] PICK_J = 3'b100;

  localparam logic [ERR_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic             s1_vld_q;
  logic [31:0]      s1_instr_q;
  logic [31:0]      s1_imm_q;
  logic [2:0]       s1_pick_q;
  logic             s1_err_q;
  logic             s1_err_d;

  logic             s2_vld_q;
  logic [31:0]      s2_instr_q;
  logic [31:0]      s2_instr_d;
  logic             s2_err_q;

  logic [ERR_W-1:0] cnt_q;
  logic [ERR_W-1:0] cnt_d;

  logic             adv2;
  logic             adv1;
  logic             err_xfer;

  assign adv2     = ~s2_vld_q | OUT_READY;
  assign adv1     = ~s1_vld_q | adv2;
  assign IN_READY = adv1;

  // Sign-extension style checks: the high bits must all match the top encoded bit.
  always_comb begin
    s1_err_d = 1'b0;
    case (IN_IMM_PICK)
      PICK_I, PICK_S: s1_err_d = ~((&IN_IMMEDIATE[31:11]) | ~(|IN_IMMEDIATE[31:11]));
      PICK_U:         s1_err_d = |IN_IMMEDIATE[11:0];
      PICK_B:         s1_err_d = ~((&IN_IMMEDIATE[31:12]) | ~(|IN_IMMEDIATE[31:12]))
                                 | IN_IMMEDIATE[0];
      PICK_J:         s1_err_d = ~((&IN_IMMEDIATE[31:20]) | ~(|IN_IMMEDIATE[31:20]))
                                 | IN_IMMEDIATE[0];
      default:        s1_err_d = 1'b1;
    endcase
  end

  always_comb begin
    s2_instr_d = s1_instr_q;
    case (s1_pick_q)
      PICK_I: s2_instr_d[31:20] = s1_imm_q[11:0];
      PICK_S: begin
        s2_instr_d[31:25] = s1_imm_q[11:5];
        s2_instr_d[11:7]  = s1_imm_q[4:0];
      end
      PICK_U: s2_instr_d[31:12] = s1_imm_q[31:12];
      PICK_B: begin
        s2_instr_d[31]    = s1_imm_q[12];
        s2_instr_d[30:25] = s1_imm_q[10:5];
        s2_instr_d[11:8]  = s1_imm_q[4:1];
        s2_instr_d[7]     = s1_imm_q[11];
      end
      PICK_J: begin
        s2_instr_d[31]    = s1_imm_q[20];
        s2_instr_d[30:21] = s1_imm_q[10:1];
        s2_instr_d[20]    = s1_imm_q[11];
        s2_instr_d[19:12] = s1_imm_q[19:12];
      end
      default: s2_instr_d = s1_instr_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_vld_q   <= 1'b0;
      s1_instr_q <= '0;
      s1_imm_q   <= '0;
      s1_pick_q  <= '0;
      s1_err_q   <= 1'b0;
    end else if (adv1) begin
      s1_vld_q <= IN_VALID;
      if (IN_VALID) begin
        s1_instr_q <= IN_INSTRUCTION;
        s1_imm_q   <= IN_IMMEDIATE;
        s1_pick_q  <= IN_IMM_PICK;
        s1_err_q   <= s1_err_d;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s2_vld_q   <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else if (adv2) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_instr_q <= s2_instr_d;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  assign err_xfer = s2_vld_q & OUT_READY & s2_err_q;

  // A clear that lands on a counted transfer keeps that one event.
  always_comb begin
    cnt_d = cnt_q;
    if (CLR_ERR)
      cnt_d = err_xfer ? CNT_ONE : '0;
    else if (err_xfer && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign OUT_VALID       = s2_vld_q;
  assign OUT_INSTRUCTION = s2_instr_q;
  assign OUT_RANGE_ERR   = s2_err_q;
  assign ERR_COUNT       = cnt_q;

endmodule
